i2c_master_arbiter: RTL and testbench



---
 rtl/i2c_pkg.sv | 14 +
 rtl/rr_pick.sv | 19 +
 rtl/i2c_master_arbiter.sv | 151 +++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared widths and state encodings for the I2C master arbiter
package i2c_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 7;
    localparam int SIZE_W = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_first;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    assign w_rot   = N'({req, req} >> ptr);
    assign w_first = w_rot & (-w_rot);
    assign grant   = N'(({w_first, w_first} << ptr) >> N);

endmodule

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin sharing of one I2C master among N requesters
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int N         = 2,
    parameter int LAUNCH_TO = 255,
    parameter int RUN_TO    = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          cl_req,
    input  logic [N-1:0]          cl_rnw,
    input  logic [ADDR_W*N-1:0]   cl_addr,
    input  logic [SIZE_W*N-1:0]   cl_size,
    input  logic [DATA_W*N-1:0]   cl_data_i,
    input  logic [N-1:0]          cl_data_valid,
    output logic [N-1:0]          cl_grant,
    output logic [N-1:0]          cl_data_request,
    output logic [N-1:0]          cl_data_available,
    output logic [N-1:0]          cl_done,
    output logic [N-1:0]          cl_err,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  m_start,
    input  logic                  m_ready,
    input  logic                  m_busy,
    input  logic                  m_data_request,
    input  logic                  m_data_available,
    input  logic [DATA_W-1:0]     m_data_o,
    output logic                  m_read_nwrite,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [SIZE_W-1:0]     m_data_size,
    output logic [DATA_W-1:0]     m_data_i,
    output logic                  m_data_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [2:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [N-1:0]  r_req;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_done;
    logic [N-1:0]  r_err;
    logic          r_start;
    logic [7:0]    r_launch_cnt;
    logic [15:0]   r_run_cnt;

    logic [N-1:0]  w_pick;
    logic [PW-1:0] w_next_ptr;

    // Requests are frozen on leaving IDLE so a late raiser waits for the next round.
    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (r_req),
        .ptr   (r_ptr),
        .grant (w_pick)
    );

    always_comb begin
        w_next_ptr = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) w_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_req        <= '0;
            r_grant      <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_start      <= 1'b0;
            r_launch_cnt <= '0;
            r_run_cnt    <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    r_launch_cnt <= '0;
                    r_run_cnt    <= '0;
                    if (|cl_req && m_ready && !m_busy) begin
                        r_req   <= cl_req;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_grant <= w_pick;
                    r_start <= 1'b1;
                    r_state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    r_launch_cnt <= r_launch_cnt + 8'd1;
                    if (!m_ready) begin
                        r_start <= 1'b0;
                        r_state <= S_RUN;
                    end else if (r_launch_cnt == 8'(LAUNCH_TO - 1)) begin
                        r_start <= 1'b0;
                        r_done  <= r_grant;
                        r_err   <= r_grant;
                        r_state <= S_DONE;
                    end
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + 16'd1;
                    if (m_ready && !r_start) begin
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end else if (r_run_cnt == 16'(RUN_TO - 1)) begin
                        r_done  <= r_grant;
                        r_err   <= r_grant;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_ptr   <= w_next_ptr;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        m_addr        = '0;
        m_read_nwrite = 1'b0;
        m_data_size   = '0;
        m_data_i      = '0;
        m_data_valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                m_addr        = cl_addr[ADDR_W*i +: ADDR_W];
                m_read_nwrite = cl_rnw[i];
                m_data_size   = cl_size[SIZE_W*i +: SIZE_W];
                m_data_i      = cl_data_i[DATA_W*i +: DATA_W];
                m_data_valid  = cl_data_valid[i];
            end
        end
    end

    assign cl_grant          = r_grant;
    assign cl_done           = r_done;
    assign cl_err            = r_err;
    assign m_start           = r_start;
    assign rd_data           = m_data_o;
    assign cl_data_request   = {N{m_data_request}} & r_grant;
    assign cl_data_available = {N{m_data_available}} & r_grant;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - directed self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   cl_req, cl_rnw, cl_data_valid;
    logic [7*N-1:0] cl_addr;
    logic [3*N-1:0] cl_size;
    logic [8*N-1:0] cl_data_i;
    logic [N-1:0]   cl_grant, cl_data_request, cl_data_available, cl_done, cl_err;
    logic [7:0]     rd_data, m_data_o, m_data_i;
    logic           m_start, m_ready, m_busy, m_data_request, m_data_available;
    logic           m_read_nwrite, m_data_valid;
    logic [6:0]     m_addr;
    logic [2:0]     m_data_size;

    i2c_master_arbiter #(.N(N), .LAUNCH_TO(8), .RUN_TO(40)) dut (
        .clk(clk), .rst(rst),
        .cl_req(cl_req), .cl_rnw(cl_rnw), .cl_addr(cl_addr), .cl_size(cl_size),
        .cl_data_i(cl_data_i), .cl_data_valid(cl_data_valid),
        .cl_grant(cl_grant), .cl_data_request(cl_data_request),
        .cl_data_available(cl_data_available), .cl_done(cl_done), .cl_err(cl_err),
        .rd_data(rd_data), .m_start(m_start), .m_ready(m_ready), .m_busy(m_busy),
        .m_data_request(m_data_request), .m_data_available(m_data_available),
        .m_data_o(m_data_o), .m_read_nwrite(m_read_nwrite), .m_addr(m_addr),
        .m_data_size(m_data_size), .m_data_i(m_data_i), .m_data_valid(m_data_valid)
    );

    typedef struct {
        int         client;
        logic       rnw;
        logic [6:0] addr;
        logic [2:0] size;
        logic [55:0] bytes;
        logic [1:0] exp_grant;
        logic [6:0] exp_addr;
        logic [2:0] exp_size;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[5];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic setup_client(input int c, input logic rnw, input logic [6:0] addr,
                                input logic [2:0] size, input logic [7:0] byte0);
        int o;
        o = 1 - c;
        cl_rnw[c] = rnw;           cl_rnw[o] = ~rnw;
        cl_addr[7*c +: 7] = addr;  cl_addr[7*o +: 7] = ~addr;
        cl_size[3*c +: 3] = size;  cl_size[3*o +: 3] = ~size;
        cl_data_i[8*c +: 8] = byte0; cl_data_i[8*o +: 8] = 8'hEE;
        cl_data_valid[c] = ~rnw;   cl_data_valid[o] = rnw;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input logic [1:0] exp_done, input logic [1:0] exp_err, input int bound);
        bit found;
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (cl_done != '0) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(found), 32'd1);
        check("cl_done", 32'(cl_done), 32'(exp_done));
        check("cl_err", 32'(cl_err), 32'(exp_err));
        cl_req = cl_req & ~cl_done;
        tick();
        check("grant_cleared", 32'(cl_grant), 32'd0);
        check("idle_size", 32'(m_data_size), 32'd0);
    endtask

    task automatic do_txn(input int c, input logic rnw, input int nbytes, input logic [55:0] bytes,
                          input logic [1:0] exp_grant, input logic [6:0] exp_addr,
                          input logic [2:0] exp_size, input logic exp_valid);
        bit ok;
        logic [7:0] b;
        wait_start(ok);
        check("start_seen", 32'(ok), 32'd1);
        check("grant", 32'(cl_grant), 32'(exp_grant));
        check("m_addr", 32'(m_addr), 32'(exp_addr));
        check("m_size", 32'(m_data_size), 32'(exp_size));
        check("m_rnw", 32'(m_read_nwrite), 32'(rnw));
        check("m_valid", 32'(m_data_valid), 32'(exp_valid));
        tick();
        tick();
        m_ready = 1'b0;
        tick();
        check("start_dropped", 32'(m_start), 32'd0);
        for (int k = 0; k < nbytes; k++) begin
            b = bytes[55 - 8*k -: 8];
            tick();
            if (rnw) begin
                m_data_o = b;
                m_data_available = 1'b1;
                #1;
                check("rd_avail", 32'(cl_data_available), 32'(exp_grant));
                check("rd_req_quiet", 32'(cl_data_request), 32'd0);
                check("rd_data", 32'(rd_data), 32'(b));
            end else begin
                m_data_request = 1'b1;
                #1;
                check("wr_req", 32'(cl_data_request), 32'(exp_grant));
                check("wr_avail_quiet", 32'(cl_data_available), 32'd0);
                check("wr_data", 32'(m_data_i), 32'(b));
            end
            tick();
            m_data_available = 1'b0;
            m_data_request = 1'b0;
            if (!rnw && k < 6) cl_data_i[8*c +: 8] = bytes[47 - 8*k -: 8];
        end
        tick();
        m_ready = 1'b1;
        wait_done(exp_grant, 2'b00, 20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit seen;
        int cnt;

        vecs[0] = '{client:0, rnw:1'b1, addr:7'h40, size:3'd4, bytes:{8'h11,8'h22,8'h33,8'h44,24'h0},
                    exp_grant:2'b01, exp_addr:7'h40, exp_size:3'd4, exp_valid:1'b0};
        vecs[1] = '{client:1, rnw:1'b0, addr:7'h2A, size:3'd3, bytes:{8'hA5,8'h02,8'h00,32'h0},
                    exp_grant:2'b10, exp_addr:7'h2A, exp_size:3'd3, exp_valid:1'b1};
        vecs[2] = '{client:0, rnw:1'b0, addr:7'h7F, size:3'd1, bytes:{8'h5A,48'h0},
                    exp_grant:2'b01, exp_addr:7'h7F, exp_size:3'd1, exp_valid:1'b1};
        vecs[3] = '{client:1, rnw:1'b1, addr:7'h00, size:3'd7,
                    bytes:{8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07},
                    exp_grant:2'b10, exp_addr:7'h00, exp_size:3'd7, exp_valid:1'b0};
        vecs[4] = '{client:0, rnw:1'b1, addr:7'h13, size:3'd0, bytes:56'h0,
                    exp_grant:2'b01, exp_addr:7'h13, exp_size:3'd0, exp_valid:1'b0};

        rst = 1'b0;
        cl_req = '0; cl_rnw = '0; cl_addr = '0; cl_size = '0; cl_data_i = '0; cl_data_valid = '0;
        m_ready = 1'b0; m_busy = 1'b0; m_data_request = 1'b0; m_data_available = 1'b0; m_data_o = '0;
        repeat (3) tick();
        check("rst_grant", 32'(cl_grant), 32'd0);
        check("rst_done", 32'(cl_done), 32'd0);
        check("rst_err", 32'(cl_err), 32'd0);
        check("rst_start", 32'(m_start), 32'd0);
        check("rst_size", 32'(m_data_size), 32'd0);
        check("rst_addr", 32'(m_addr), 32'd0);
        rst = 1'b1;
        m_ready = 1'b1;
        tick();

        // Simultaneous requests, then client 0 re-requests while 1 is still pending.
        cl_rnw = 2'b11; cl_addr = {7'h21, 7'h40}; cl_size = {3'd2, 3'd4};
        cl_req = 2'b11;
        do_txn(0, 1'b1, 4, {8'h11,8'h22,8'h33,8'h44,24'h0}, 2'b01, 7'h40, 3'd4, 1'b0);
        cl_req[0] = 1'b1;
        do_txn(1, 1'b1, 2, {8'hAB,8'hCD,40'h0}, 2'b10, 7'h21, 3'd2, 1'b0);
        do_txn(0, 1'b1, 4, {8'h11,8'h22,8'h33,8'h44,24'h0}, 2'b01, 7'h40, 3'd4, 1'b0);

        for (int v = 0; v < 5; v++) begin
            setup_client(vecs[v].client, vecs[v].rnw, vecs[v].addr, vecs[v].size, vecs[v].bytes[55:48]);
            cl_req = '0;
            cl_req[vecs[v].client] = 1'b1;
            do_txn(vecs[v].client, vecs[v].rnw, int'(vecs[v].size), vecs[v].bytes,
                   vecs[v].exp_grant, vecs[v].exp_addr, vecs[v].exp_size, vecs[v].exp_valid);
        end

        // Launch timeout: ready never falls.
        cl_req = 2'b01;
        wait_start(ok);
        check("to_start_seen", 32'(ok), 32'd1);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_start) cnt++;
            else break;
        end
        check("to_start_cycles", 32'(cnt), 32'd8);
        check("to_done", 32'(cl_done), 32'b01);
        check("to_err", 32'(cl_err), 32'b01);
        cl_req = cl_req & ~cl_done;
        tick();
        check("to_grant_cleared", 32'(cl_grant), 32'd0);

        // After a timeout the master may still be mid-frame: no grant until ready.
        m_ready = 1'b0;
        setup_client(1, 1'b1, 7'h55, 3'd1, 8'h00);
        cl_req = 2'b10;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (cl_grant != '0 || m_start) seen = 1'b1;
        end
        check("ready_low_no_grant", 32'(seen), 32'd0);
        m_ready = 1'b1;
        do_txn(1, 1'b1, 1, {8'h99,48'h0}, 2'b10, 7'h55, 3'd1, 1'b0);

        // Bus busy holds off the grant.
        setup_client(0, 1'b0, 7'h3C, 3'd2, 8'h81);
        cl_req = 2'b01;
        m_busy = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (cl_grant != '0 || m_start) seen = 1'b1;
        end
        check("busy_no_grant", 32'(seen), 32'd0);
        m_busy = 1'b0;
        tick();
        check("busy_grant_state", 32'(cl_grant), 32'd0);
        tick();
        check("busy_grant_next", 32'(cl_grant), 32'b01);
        do_txn(0, 1'b0, 2, {8'h81,8'h7E,40'h0}, 2'b01, 7'h3C, 3'd2, 1'b1);

        // Reset while the master is running.
        setup_client(1, 1'b1, 7'h0F, 3'd3, 8'h00);
        cl_req = 2'b10;
        wait_start(ok);
        check("mr_start_seen", 32'(ok), 32'd1);
        tick();
        tick();
        m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("mr_grant", 32'(cl_grant), 32'd0);
        check("mr_start", 32'(m_start), 32'd0);
        check("mr_size", 32'(m_data_size), 32'd0);
        check("mr_addr", 32'(m_addr), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        m_ready = 1'b1;
        cl_req = 2'b00;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (cl_done != '0 || cl_err != '0 || cl_grant != '0) seen = 1'b1;
        end
        check("mr_no_spurious", 32'(seen), 32'd0);

        // Pointer back at 0: both requesting gives client 0 first.
        cl_rnw = 2'b11; cl_addr = {7'h62, 7'h61}; cl_size = {3'd1, 3'd1}; cl_data_valid = 2'b00;
        cl_req = 2'b11;
        do_txn(0, 1'b1, 1, {8'h3A,48'h0}, 2'b01, 7'h61, 3'd1, 1'b0);
        do_txn(1, 1'b1, 1, {8'h3B,48'h0}, 2'b10, 7'h62, 3'd1, 1'b0);

        // Client 0 raising during GRANT must not displace client 1.
        cl_req = 2'b10;
        tick();
        cl_req[0] = 1'b1;
        do_txn(1, 1'b1, 1, {8'h3C,48'h0}, 2'b10, 7'h62, 3'd1, 1'b0);
        do_txn(0, 1'b1, 1, {8'h3D,48'h0}, 2'b01, 7'h61, 3'd1, 1'b0);

        // Run timeout: ready falls and never returns.
        setup_client(1, 1'b1, 7'h44, 3'd2, 8'h00);
        cl_req = 2'b10;
        wait_start(ok);
        check("rt_start_seen", 32'(ok), 32'd1);
        tick();
        tick();
        m_ready = 1'b0;
        wait_done(2'b10, 2'b10, 80);
        m_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
